// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store memory master
package lsu_pkg;

   localparam int LANE_W = 2;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } lsu_size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } lsu_state_e;

   // Misaligned half/word or the reserved size encoding.
   function automatic logic lsu_req_err(lsu_size_e size, logic [LANE_W-1:0] off);
      case (size)
         SZ_HALF: return off[0];
         SZ_WORD: return off != '0;
         SZ_ILL:  return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend for loads, byte/half merge for stores
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int X_LEN = 32
) (
   input  lsu_size_e          size,
   input  logic               uns,
   input  logic [LANE_W-1:0]  off,
   input  logic [X_LEN-1:0]   rdata,
   input  logic [X_LEN-1:0]   wdata,
   output logic [X_LEN-1:0]   load_data,
   output logic [X_LEN-1:0]   merge_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane  = rdata[{off, 3'b000} +: 8];
      half_lane  = rdata[{off[1], 4'b0000} +: 16];
      load_data  = rdata;
      merge_data = rdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{(X_LEN-8){~uns & byte_lane[7]}}, byte_lane};
            merge_data[{off, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data = {{(X_LEN-16){~uns & half_lane[15]}}, half_lane};
            merge_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
         end
         SZ_WORD: merge_data = wdata;
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - MEM-stage load/store controller with read-modify-write for sub-word stores
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int X_LEN = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_we_i,
   input  logic [1:0]       req_size_i,
   input  logic             req_unsigned_i,
   input  logic [X_LEN-1:0] req_addr_i,
   input  logic [X_LEN-1:0] req_wdata_i,
   output logic             rsp_valid_o,
   output logic [X_LEN-1:0] rsp_rdata_o,
   output logic             rsp_err_o,
   output logic             mem_we_o,
   output logic [X_LEN-1:0] mem_addr_o,
   output logic [X_LEN-1:0] mem_wdata_o,
   input  logic [X_LEN-1:0] mem_rdata_i
);

   lsu_state_e       state;
   logic             req_we_q;
   lsu_size_e        req_size_q;
   logic             req_uns_q;
   logic [X_LEN-1:0] req_addr_q;
   logic [X_LEN-1:0] req_wdata_q;
   logic [X_LEN-1:0] merge_q;
   logic [X_LEN-1:0] rsp_data_q;
   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic             ready_q;
   logic             mem_en_q;
   logic             mem_we_q;
   logic [X_LEN-1:0] load_data;
   logic [X_LEN-1:0] merge_data;

   lsu_lane_align #(.X_LEN(X_LEN)) u_align (
      .size       (req_size_q),
      .uns        (req_uns_q),
      .off        (req_addr_q[LANE_W-1:0]),
      .rdata      (mem_rdata_i),
      .wdata      (req_wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Address is gated by a registered enable so it reads back as zero outside memory phases.
   assign mem_addr_o  = mem_en_q ? {req_addr_q[X_LEN-1:LANE_W], {LANE_W{1'b0}}} : '0;
   assign mem_we_o    = mem_we_q & req_we_q;
   assign mem_wdata_o = merge_q;
   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         req_we_q    <= 1'b0;
         req_size_q  <= SZ_BYTE;
         req_uns_q   <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         merge_q     <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         ready_q     <= 1'b1;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  req_we_q    <= req_we_i;
                  req_size_q  <= lsu_size_e'(req_size_i);
                  req_uns_q   <= req_unsigned_i;
                  req_addr_q  <= req_addr_i;
                  req_wdata_q <= req_wdata_i;
                  ready_q     <= 1'b0;
                  if (lsu_req_err(lsu_size_e'(req_size_i), req_addr_i[LANE_W-1:0])) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     state       <= ST_RESP;
                  end else if (!req_we_i) begin
                     mem_en_q <= 1'b1;
                     state    <= ST_LOAD;
                  end else if (lsu_size_e'(req_size_i) == SZ_WORD) begin
                     mem_en_q <= 1'b1;
                     mem_we_q <= 1'b1;
                     merge_q  <= req_wdata_i;
                     state    <= ST_WRITE;
                  end else begin
                     mem_en_q <= 1'b1;
                     state    <= ST_READ;
                  end
               end
            end
            ST_LOAD: begin
               rsp_data_q  <= load_data;
               rsp_valid_q <= 1'b1;
               mem_en_q    <= 1'b0;
               state       <= ST_RESP;
            end
            ST_READ: begin
               merge_q  <= merge_data;
               mem_we_q <= 1'b1;
               state    <= ST_WRITE;
            end
            ST_WRITE: begin
               merge_q     <= '0;
               mem_we_q    <= 1'b0;
               mem_en_q    <= 1'b0;
               rsp_valid_q <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_data_q  <= '0;
               ready_q     <= 1'b1;
               state       <= ST_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
